ifmap_stream_packer: RTL and testbench

- Producer side of the PE input-feature-map stream.
- Fetches a rectangular block of IFMap pixels from a word-addressed feature memory (1-cycle read latency).
- Tags each word with row markers: bit IFMAP_WIDTH-1 = start-of-row, bit IFMAP_WIDTH-2 = end-of-row.
- Pushes tagged words into the PE IFMap FIFO through its write_enable/ready handshake, using a 2-entry skid queue so no word is lost under backpressure.

---
 rtl/ifmap_stream_packer_pkg.sv | 19 +
 rtl/skid_queue2.sv | 68 ++++++
 rtl/ifmap_stream_packer.sv | 155 +++++++++++++++
 tb/tb_ifmap_stream_packer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_stream_packer_pkg.sv
// Shared types and constants for the IFMap stream packer and its skid queue.
// Tag positions assume the default 18-bit tagged word: {sor, eor, pixel[15:0]}.
package ifmap_stream_packer_pkg;

   localparam int IFMAP_WIDTH_DEF = 18;
   localparam int SOR_BIT         = IFMAP_WIDTH_DEF - 1;
   localparam int EOR_BIT         = IFMAP_WIDTH_DEF - 2;

   localparam int SKID_DEPTH = 2;
   localparam int SKID_CNT_W = 2;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/skid_queue2.sv
// Two-entry first-in first-out queue; the head entry is always visible on dout.
// Shared by the IFMap packer and the filter feeder.
module skid_queue2
   import ifmap_stream_packer_pkg::*;
#(
   parameter int WIDTH = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [SKID_CNT_W-1:0] count
);

   logic [WIDTH-1:0]      head_q, head_d;
   logic [WIDTH-1:0]      tail_q, tail_d;
   logic [SKID_CNT_W-1:0] count_q, count_d;
   logic                  pop_eff;

   assign pop_eff = pop && (count_q != '0);

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned, which would infer a latch.
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      unique case ({push, pop_eff})
         2'b10: begin
            if (count_q == '0) head_d = din;
            else               tail_d = din;
            count_d = count_q + SKID_CNT_W'(1);
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - SKID_CNT_W'(1);
         end
         2'b11: begin
            if (count_q == SKID_CNT_W'(1)) begin
               head_d = din;
            end else begin
               head_d = tail_q;
               tail_d = din;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: storage is reset as well, because the head drives the output word directly and must read 0 after reset.
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign dout  = head_q;
   assign count = count_q;

endmodule

// File: rtl/ifmap_stream_packer.sv
// Fetches a row_len x row_count pixel block from feature memory, tags row
// boundaries and streams the words into the PE IFMap FIFO through a skid queue.
module ifmap_stream_packer
   import ifmap_stream_packer_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int IFMAP_WIDTH  = 18,
   parameter int ADDR_WIDTH   = 16,
   parameter int ROW_LEN_SIZE = 8,
   parameter int ROW_CNT_SIZE = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [ROW_LEN_SIZE-1:0] row_len,
   input  logic [ROW_CNT_SIZE-1:0] row_count,
   output logic                    mem_ren,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    buf_ready,
   output logic [IFMAP_WIDTH-1:0]  IFMap_out,
   output logic                    wen_IFMap,
   output logic                    busy,
   output logic                    done
);

   localparam logic [SKID_CNT_W:0] DEPTH_L = (SKID_CNT_W + 1)'(SKID_DEPTH);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [ROW_LEN_SIZE-1:0] len_q, len_d;
   logic [ROW_LEN_SIZE-1:0] col_q, col_d;
   logic [ROW_CNT_SIZE-1:0] cnt_q, cnt_d;
   logic [ROW_CNT_SIZE-1:0] row_q, row_d;
   logic                    inflight_q, inflight_d;
   logic [1:0]              tag_q, tag_d;

   logic [SKID_CNT_W-1:0]   occ;
   logic [SKID_CNT_W:0]     slots_net;
   logic                    issue_ok, issue, last_col, last_read;
   logic [IFMAP_WIDTH-1:0]  skid_din;

   assign wen_IFMap = (occ != '0) && buf_ready;

   // A word popped this cycle frees its slot for a read issued this cycle.
   assign slots_net = {1'b0, occ} + {{SKID_CNT_W{1'b0}}, inflight_q} - {{SKID_CNT_W{1'b0}}, wen_IFMap};
   assign issue_ok  = slots_net < DEPTH_L;
   assign last_col  = (col_q == len_q - ROW_LEN_SIZE'(1));
   assign last_read = last_col && (row_q == cnt_q - ROW_CNT_SIZE'(1));

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      idx_d   = idx_q;
      len_d   = len_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      tag_d   = tag_q;
      issue   = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if ((row_len != '0) && (row_count != '0)) begin
                  base_d  = base_addr;
                  len_d   = row_len;
                  cnt_d   = row_count;
                  idx_d   = '0;
                  col_d   = '0;
                  row_d   = '0;
                  state_d = FETCH;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FETCH: begin
            if (issue_ok) begin
               issue = 1'b1;
               tag_d = {col_q == '0, last_col};
               idx_d = idx_q + ADDR_WIDTH'(1);
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + ROW_CNT_SIZE'(1);
               end else begin
                  col_d = col_q + ROW_LEN_SIZE'(1);
               end
               if (last_read) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Leave as the final word is written so done follows it by one cycle.
            if (!inflight_q && ((occ == '0) || ((occ == SKID_CNT_W'(1)) && wen_IFMap)))
               state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      inflight_d = issue;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         idx_q      <= '0;
         len_q      <= '0;
         col_q      <= '0;
         cnt_q      <= '0;
         row_q      <= '0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         col_q      <= col_d;
         cnt_q      <= cnt_d;
         row_q      <= row_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
      end
   end

   always_comb begin
      skid_din                   = '0;
      skid_din[DATA_WIDTH-1:0]   = mem_rdata;
      skid_din[SOR_BIT]          = tag_q[1];
      skid_din[EOR_BIT]          = tag_q[0];
   end

   skid_queue2 #(
      .WIDTH(IFMAP_WIDTH)
   ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .push (inflight_q),
      .pop  (wen_IFMap),
      .din  (skid_din),
      .dout (IFMap_out),
      .count(occ)
   );

   assign mem_ren  = issue;
   assign mem_addr = base_q + idx_q;
   assign busy     = (state_q == FETCH) || (state_q == DRAIN);

endmodule

// File: tb/tb_ifmap_stream_packer.sv
// Scoreboard bench for ifmap_stream_packer: a table of jobs plus hand-written
// sequences for the literal word list, ignored restart and mid-job reset.
module tb_ifmap_stream_packer;
   import ifmap_stream_packer_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [7:0]  row_len = '0;
   logic [7:0]  row_count = '0;
   logic        mem_ren;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata = '0;
   logic        buf_ready = 1'b0;
   logic [17:0] IFMap_out;
   logic        wen_IFMap;
   logic        busy;
   logic        done;

   ifmap_stream_packer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base_addr(base_addr),
      .row_len  (row_len),
      .row_count(row_count),
      .mem_ren  (mem_ren),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .buf_ready(buf_ready),
      .IFMap_out(IFMap_out),
      .wen_IFMap(wen_IFMap),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Feature memory returns its own address as data, one cycle after mem_ren.
   always @(posedge clk) if (mem_ren) mem_rdata <= mem_addr;

   int vectors = 0;
   int miscompares = 0;
   logic [17:0] exp_q[$];
   int ready_mode = 0;
   int wr_cnt, ren_cnt, first_wen_cyc, last_wen_cyc, done_cyc, start_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // buf_ready: 0 = always high, 1 = repeating 1-0-0-1, other = held low.
   initial forever begin
      @(posedge clk); #1;
      case (ready_mode)
         0:       buf_ready = 1'b1;
         1:       buf_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         default: buf_ready = 1'b0;
      endcase
   end

   initial forever begin
      logic [1:0] occ;
      @(negedge clk);
      if (mem_ren) ren_cnt++;
      if (wen_IFMap) begin
         wr_cnt++;
         last_wen_cyc = cyc;
         if (first_wen_cyc < 0) first_wen_cyc = cyc;
         if (exp_q.size() == 0) check("unexpected_write", {14'd0, IFMap_out}, 32'hFFFF_FFFF);
         else                   check("word", {14'd0, IFMap_out}, {14'd0, exp_q.pop_front()});
      end
      if (done) begin
         done_cyc = cyc;
         if (wen_IFMap) check("done_with_wen", 1, 0);
         if (busy)      check("busy_with_done", 1, 0);
      end
      occ = dut.u_skid.count;
      if (occ > 2'd2) check("skid_occupancy", {30'd0, occ}, 2);
      if ((occ == 2'd2) && !buf_ready && mem_ren) check("ren_while_full", 1, 0);
   end

   task automatic run_job(input logic [15:0] b, input logic [7:0] len, input logic [7:0] cnt,
                          input int mode, input bit second, input bit gen_exp, input int exp_writes);
      bit got = 0;
      if (gen_exp)
         for (int r = 0; r < int'(cnt); r++)
            for (int c = 0; c < int'(len); c++) begin
               logic [15:0] a;
               a = b + 16'(r * int'(len) + c);
               exp_q.push_back({c == 0, c == int'(len) - 1, a});
            end
      ready_mode = mode;
      @(posedge clk); #1;
      wr_cnt = 0; ren_cnt = 0; first_wen_cyc = -1; last_wen_cyc = -1; done_cyc = -1;
      start = 1'b1; base_addr = b; row_len = len; row_count = cnt;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 16'hDEAD; row_len = 8'd7; row_count = 8'd5;
      @(negedge clk);
      check("busy_after_start", busy, exp_writes > 0);
      if (second) begin
         @(posedge clk); #1;
         start = 1'b1; base_addr = 16'h0100; row_len = 8'd1; row_count = 8'd1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int i = 0; i < 400; i++) begin
         if (done) begin got = 1; break; end
         @(negedge clk);
      end
      @(posedge clk); #1;
      check("done_seen", got, 1);
      check("write_count", wr_cnt, exp_writes);
      check("read_count", ren_cnt, exp_writes);
      check("queue_empty", exp_q.size(), 0);
      if (exp_writes > 0) begin
         check("done_after_last_write", done_cyc - last_wen_cyc, 1);
         if (mode == 0) begin
            check("first_write_latency", first_wen_cyc - start_cyc, 3);
            check("one_word_per_cycle", last_wen_cyc - first_wen_cyc, exp_writes - 1);
         end
      end else begin
         check("done_after_start", done_cyc - start_cyc, 1);
      end
      exp_q.delete();
   endtask

   typedef struct {
      logic [15:0] base;
      logic [7:0]  len;
      logic [7:0]  cnt;
      int          mode;
      bit          second;
      int          exp_writes;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{16'h0020, 8'd1, 8'd3, 0, 1'b0, 3};
      tbl[1] = '{16'h0010, 8'd4, 8'd2, 1, 1'b0, 8};
      tbl[2] = '{16'hFFFE, 8'd4, 8'd1, 0, 1'b0, 4};
      tbl[3] = '{16'h0000, 8'd4, 8'd0, 0, 1'b0, 0};
      tbl[4] = '{16'h0030, 8'd0, 8'd3, 0, 1'b0, 0};
      tbl[5] = '{16'h0010, 8'd4, 8'd2, 0, 1'b1, 8};
      tbl[6] = '{16'h0100, 8'd3, 8'd3, 1, 1'b0, 9};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_ren", mem_ren, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_wen", wen_IFMap, 0);
      check("rst_ifmap_out", IFMap_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Literal word list for base 0x0010, 4x2.
      exp_q.push_back(18'h20010); exp_q.push_back(18'h00011);
      exp_q.push_back(18'h00012); exp_q.push_back(18'h10013);
      exp_q.push_back(18'h20014); exp_q.push_back(18'h00015);
      exp_q.push_back(18'h00016); exp_q.push_back(18'h10017);
      run_job(16'h0010, 8'd4, 8'd2, 0, 1'b0, 1'b0, 8);

      for (int i = 0; i < 7; i++)
         run_job(tbl[i].base, tbl[i].len, tbl[i].cnt, tbl[i].mode, tbl[i].second, 1'b1, tbl[i].exp_writes);

      // Reset mid-row with the FIFO stalled and a read in flight.
      ready_mode = 2;
      @(posedge clk); #1;
      start = 1'b1; base_addr = 16'h0040; row_len = 8'd8; row_count = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ren_cnt = 0; wr_cnt = 0;
      @(negedge clk);
      check("abort_mem_ren", mem_ren, 0);
      check("abort_mem_addr", mem_addr, 0);
      check("abort_wen", wen_IFMap, 0);
      check("abort_ifmap_out", IFMap_out, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      ready_mode = 0;
      repeat (6) @(negedge clk);
      check("abort_no_reads", ren_cnt, 0);
      check("abort_no_writes", wr_cnt, 0);
      run_job(16'h0080, 8'd3, 8'd2, 0, 1'b0, 1'b1, 6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
